// File: rtl/seq_cla_chunked_alu_pkg.sv
// Shared definitions for the chunked carry-look-ahead ALU: op codes,
// FSM encodings and default geometry.
package seq_cla_chunked_alu_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 7;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    CALC   = 2'b10,
    SEND   = 2'b11
  } state_t;

  // Beats needed to carry a w-bit value over a c-bit bus.
  function automatic int num_chunks(input int w, input int c);
    return (w + c - 1) / c;
  endfunction

endpackage

// File: rtl/carry_look_ahead.sv
// Shared generate/propagate adder: s = a + b + y, c = carry-out.
module carry_look_ahead #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             y,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Carry recurrence c[i+1] = g[i] | p[i]&c[i]; synthesis flattens it into lookahead terms.
  always_comb begin
    logic cur;
    cur = y;
    s   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = prop[i] ^ cur;
      cur  = gen[i] | (prop[i] & cur);
    end
    c = cur;
  end

endmodule

// File: rtl/seq_cla_chunked_alu.sv
// Chunked-operand add/sub/accumulate unit: operands arrive LSB chunk first,
// one CLA pass computes the result, which is returned in chunks with a carry flag.
module seq_cla_chunked_alu
  import seq_cla_chunked_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_data,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic             out_carry
);

  localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int PW     = (PADW > 1) ? $clog2(PADW) : 1;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [1:0]       op_q, op_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic             carry_q, carry_n;
  logic [WIDTH-1:0] acc, acc_n;

  logic [WIDTH-1:0] cla_a, cla_b, cla_s;
  logic             cla_y, cla_c;
  logic [PADW-1:0]  res_pad;
  logic [PW-1:0]    out_base;
  logic             is_last;

  // Overwrite one chunk of v; bits that land above WIDTH fall off the top.
  function automatic logic [WIDTH-1:0] put_chunk(input logic [WIDTH-1:0] v,
                                                 input int beat,
                                                 input logic [CHUNK-1:0] d);
    logic [PADW-1:0] mask;
    logic [PADW-1:0] data;
    mask = PADW'({CHUNK{1'b1}}) << (beat * CHUNK);
    data = PADW'(d) << (beat * CHUNK);
    return (v & ~WIDTH'(mask)) | WIDTH'(data);
  endfunction

  // Accumulate uses the running total as A; subtract is A + ~B + 1.
  assign cla_a = (op_q == OP_ACC) ? acc : a_q;
  assign cla_b = (op_q == OP_SUB) ? ~b_q : b_q;
  assign cla_y = (op_q == OP_SUB);

  carry_look_ahead #(.WIDTH(WIDTH)) u_cla (
    .a (cla_a),
    .b (cla_b),
    .y (cla_y),
    .s (cla_s),
    .c (cla_c)
  );

  // Zero-extending to the padded width makes the spare bits of the last output chunk read 0.
  assign res_pad  = PADW'(result_q);
  assign out_base = PW'(int'(count) * CHUNK);
  assign is_last  = (count == LAST);

  // Next-state, datapath updates and handshake outputs for the four-phase transaction.
  always_comb begin
    state_n    = state;
    count_n    = count;
    op_n       = op_q;
    a_n        = a_q;
    b_n        = b_q;
    result_n   = result_q;
    carry_n    = carry_q;
    acc_n      = acc;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    out_carry  = 1'b0;

    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (count == '0) begin
            op_n = op;
          end
          if ((count == '0) && (op == OP_ACC)) begin
            b_n = put_chunk(b_q, 0, in_data);
            if (NCHUNK == 1) begin
              state_n = CALC;
              count_n = '0;
            end else begin
              state_n = LOAD_B;
              count_n = CW'(1);
            end
          end else begin
            a_n = put_chunk(a_q, int'(count), in_data);
            if (is_last) begin
              state_n = LOAD_B;
              count_n = '0;
            end else begin
              count_n = count + 1'b1;
            end
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_n = put_chunk(b_q, int'(count), in_data);
          if (is_last) begin
            state_n = CALC;
            count_n = '0;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      CALC: begin
        result_n = cla_s;
        carry_n  = cla_c;
        if (op_q == OP_ACC) begin
          acc_n = cla_s;
        end
        state_n = SEND;
        count_n = '0;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = res_pad[out_base +: CHUNK];
        out_last  = is_last;
        out_carry = is_last & carry_q;
        if (out_ready) begin
          if (is_last) begin
            state_n = LOAD_A;
            count_n = '0;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      default: begin
        state_n = LOAD_A;
        count_n = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial transaction and clears acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_A;
      count    <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      acc      <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      op_q     <= op_n;
      a_q      <= a_n;
      b_q      <= b_n;
      result_q <= result_n;
      carry_q  <= carry_n;
      acc      <= acc_n;
    end
  end

endmodule

// File: tb/tb_seq_cla_chunked_alu.sv
// Directed self-checking bench for seq_cla_chunked_alu at WIDTH=16, CHUNK=7.
module tb_seq_cla_chunked_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       out_last;
  logic       out_carry;

  int n_asserts = 0;
  int n_fails   = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  seq_cla_chunked_alu #(.WIDTH(16), .CHUNK(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_carry (out_carry)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One input beat, driven on the falling edge and accepted on the next rising edge.
  task automatic send_chunk(input logic [6:0] d, input logic [1:0] o);
    @(negedge clk);
    check_output("in_ready before beat", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    op       = o;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Full operand load; later beats carry a different op that must be ignored.
  task automatic apply_stimulus(input logic [1:0] o, input logic [20:0] apad,
                                input logic [20:0] bpad);
    if (o != 2'b10) begin
      for (int i = 0; i < 3; i++) send_chunk(apad[7*i +: 7], (i == 0) ? o : 2'b11);
    end
    for (int i = 0; i < 3; i++) send_chunk(bpad[7*i +: 7], (o == 2'b10 && i == 0) ? o : 2'b01);
  endtask

  // Called just after the last input edge: checks the CALC gap, then all three result beats.
  task automatic read_result(input string tag, input logic [15:0] res, input logic cy);
    logic [20:0] e;
    e = {5'b0, res};
    check_output({tag, " calc gap valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) begin
      check_output($sformatf("%s beat%0d valid", tag, b), 32'(out_valid), 32'd1);
      check_output($sformatf("%s beat%0d data", tag, b), 32'(out_data), 32'(e[7*b +: 7]));
      check_output($sformatf("%s beat%0d last", tag, b), 32'(out_last), (b == 2) ? 32'd1 : 32'd0);
      check_output($sformatf("%s beat%0d carry", tag, b), 32'(out_carry),
                   (b == 2) ? 32'(cy) : 32'd0);
      @(posedge clk);
      #1;
    end
    check_output({tag, " idle valid"}, 32'(out_valid), 32'd0);
    check_output({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [20:0] e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    op        = 2'b00;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset in_ready", 32'(in_ready), 32'd1);
    check_output("reset out_valid", 32'(out_valid), 32'd0);
    check_output("reset out_last", 32'(out_last), 32'd0);
    check_output("reset out_carry", 32'(out_carry), 32'd0);
    check_output("reset out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x1234 + 0x0FFF = 0x2233, no carry.
    apply_stimulus(2'b00, 21'h01234, 21'h00FFF);
    read_result("add", 16'h2233, 1'b0);

    // 5 - 7 wraps to 0xFFFE with a borrow (carry 0).
    apply_stimulus(2'b01, 21'h00005, 21'h00007);
    read_result("sub borrow", 16'hFFFE, 1'b0);

    // 7 - 5 = 2 with no borrow (carry 1).
    apply_stimulus(2'b01, 21'h00007, 21'h00005);
    read_result("sub noborrow", 16'h0002, 1'b1);

    // 0xFFFF + 1 wraps to 0 with carry out.
    apply_stimulus(2'b00, 21'h0FFFF, 21'h00001);
    read_result("add overflow", 16'h0000, 1'b1);

    // Accumulate from zero, with an add in the middle that must leave acc alone.
    apply_stimulus(2'b10, 21'h0, 21'h00010);
    read_result("acc1", 16'h0010, 1'b0);
    apply_stimulus(2'b10, 21'h0, 21'h00010);
    read_result("acc2", 16'h0020, 1'b0);
    apply_stimulus(2'b00, 21'h00001, 21'h00001);
    read_result("add between acc", 16'h0002, 1'b0);
    apply_stimulus(2'b10, 21'h0, 21'h00010);
    read_result("acc3", 16'h0030, 1'b0);

    // Backpressure on beat 1 with a stray in_valid during SEND; 0x4100 + 0x0023 = 0x4123.
    apply_stimulus(2'b00, 21'h04100, 21'h00023);
    e = 21'h04123;
    check_output("bp calc gap valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_output("bp beat0 data", 32'(out_data), 32'(e[6:0]));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 7'h55;
    op        = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("bp hold%0d valid", k), 32'(out_valid), 32'd1);
      check_output($sformatf("bp hold%0d data", k), 32'(out_data), 32'(e[13:7]));
      check_output($sformatf("bp hold%0d last", k), 32'(out_last), 32'd0);
      check_output($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp beat2 data", 32'(out_data), 32'(e[20:14]));
    check_output("bp beat2 last", 32'(out_last), 32'd1);
    check_output("bp beat2 carry", 32'(out_carry), 32'd0);
    @(posedge clk);
    #1;
    check_output("bp idle valid", 32'(out_valid), 32'd0);

    // Asynchronous reset after four beats (in LOAD_B), between clock edges.
    send_chunk(7'h34, 2'b00);
    send_chunk(7'h24, 2'b00);
    send_chunk(7'h00, 2'b00);
    send_chunk(7'h7F, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midreset in_ready", 32'(in_ready), 32'd1);
    check_output("midreset out_valid", 32'(out_valid), 32'd0);
    check_output("midreset out_last", 32'(out_last), 32'd0);
    check_output("midreset out_carry", 32'(out_carry), 32'd0);
    check_output("midreset out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(2'b00, 21'h00001, 21'h00002);
    read_result("post reset add", 16'h0003, 1'b0);
    // acc was cleared by the reset, so accumulating 0x10 gives 0x10 again.
    apply_stimulus(2'b10, 21'h0, 21'h00010);
    read_result("post reset acc", 16'h0010, 1'b0);

    // A chunk 2 all ones: only bits 14..15 survive, so 0xC000 + 0 = 0xC000.
    apply_stimulus(2'b00, 21'h1FC000, 21'h0);
    read_result("padding", 16'hC000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
